// File: rtl/axi_sram_responder.sv
// AXI4 responder terminating one master port on a word-addressed SRAM; one write and one read outstanding.
// Latency: B one cycle after the last W handshake, first R beat one cycle after AR handshake, one beat per cycle after.
// Backpressure: all outputs registered; B and R fields hold until bready/rready, ready outputs low while busy.
module axi_sram_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int ID_WIDTH   = 14,
    parameter int MEM_WORDS  = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(MEM_WORDS);

    typedef struct packed {
        logic       err;
        logic [1:0] burst;
        logic [2:0] size;
    } xfer_t;

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    // Illegal size/burst/wrap-length combinations are flagged and then run as full-width INCR.
    function automatic xfer_t decode(input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
        xfer_t x;
        logic  wrap_ok;
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        x.err   = 1'b0;
        x.size  = size;
        x.burst = burst;
        if (size > 3'(LSB)) begin
            x.err  = 1'b1;
            x.size = 3'(LSB);
        end
        if (burst == 2'b11 || (burst == 2'b10 && !wrap_ok)) begin
            x.err   = 1'b1;
            x.burst = 2'b01;
        end
        return x;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] size,
                                                        input logic [1:0] burst, input logic [7:0] len);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] nxt;
        inc  = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   nxt = a;
            2'b10:   nxt = (a & ~mask) | ((a + inc) & mask);
            default: nxt = a + inc;
        endcase
        return nxt;
    endfunction

    function automatic logic oob(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) >> LSB) >= 32'(MEM_WORDS);
    endfunction

    function automatic logic [IDX_W-1:0] widx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a >> LSB);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // ---------------- write path ----------------
    wr_state_t             wr_state, wr_next;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_len, wr_beat;
    logic [2:0]            wr_size;
    logic [1:0]            wr_burst;
    logic                  wr_err;
    xfer_t                 aw_x;
    logic                  aw_hs, w_hs, b_hs, w_last_beat, w_beat_err;

    assign aw_x        = decode(s_axi_awsize, s_axi_awlen, s_axi_awburst);
    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign b_hs        = s_axi_bvalid && s_axi_bready;
    assign w_last_beat = (wr_beat == wr_len);
    assign w_beat_err  = oob(wr_addr) || (s_axi_wlast != w_last_beat);

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: if (aw_hs) wr_next = WR_DATA;
            WR_DATA: if (w_hs && w_last_beat) wr_next = WR_RESP;
            WR_RESP: if (b_hs) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_state      <= WR_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= 2'b00;
            wr_addr       <= '0;
            wr_len        <= '0;
            wr_beat       <= '0;
            wr_size       <= '0;
            wr_burst      <= '0;
            wr_err        <= 1'b0;
        end else begin
            wr_state      <= wr_next;
            s_axi_awready <= (wr_next == WR_IDLE);
            s_axi_wready  <= (wr_next == WR_DATA);
            s_axi_bvalid  <= (wr_next == WR_RESP);
            if (aw_hs) begin
                s_axi_bid <= s_axi_awid;
                wr_addr   <= s_axi_awaddr;
                wr_len    <= s_axi_awlen;
                wr_beat   <= 8'd0;
                wr_size   <= aw_x.size;
                wr_burst  <= aw_x.burst;
                wr_err    <= aw_x.err;
            end
            if (w_hs) begin
                wr_addr <= step_addr(wr_addr, wr_size, wr_burst, wr_len);
                wr_beat <= wr_beat + 8'd1;
                wr_err  <= wr_err || w_beat_err;
                if (w_last_beat)
                    s_axi_bresp <= (wr_err || w_beat_err) ? 2'b10 : 2'b00;
            end
        end
    end

    // SRAM contents survive reset; out-of-range beats are dropped rather than aliased.
    always_ff @(posedge clk) begin
        if (rst && w_hs && !oob(wr_addr)) begin
            for (int b = 0; b < STRB_WIDTH; b++)
                if (s_axi_wstrb[b]) mem[widx(wr_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
    end

    // ---------------- read path ----------------
    rd_state_t             rd_state, rd_next;
    logic [ADDR_WIDTH-1:0] rd_addr, src_addr;
    logic [7:0]            rd_len, rd_beat;
    logic [2:0]            rd_size;
    logic [1:0]            rd_burst;
    logic                  rd_err, src_err, src_oob;
    xfer_t                 ar_x;
    logic                  ar_hs, r_hs;

    assign ar_x     = decode(s_axi_arsize, s_axi_arlen, s_axi_arburst);
    assign ar_hs    = s_axi_arvalid && s_axi_arready;
    assign r_hs     = s_axi_rvalid && s_axi_rready;
    // The beat being loaded comes from the AR channel on acceptance, otherwise from the running address.
    assign src_addr = ar_hs ? s_axi_araddr : rd_addr;
    assign src_oob  = oob(src_addr);
    assign src_err  = (ar_hs ? ar_x.err : rd_err) || src_oob;

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_next = RD_DATA;
            RD_DATA: if (r_hs && s_axi_rlast) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_state      <= RD_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= 2'b00;
            s_axi_rlast   <= 1'b0;
            rd_addr       <= '0;
            rd_len        <= '0;
            rd_beat       <= '0;
            rd_size       <= '0;
            rd_burst      <= '0;
            rd_err        <= 1'b0;
        end else begin
            rd_state      <= rd_next;
            s_axi_arready <= (rd_next == RD_IDLE);
            s_axi_rvalid  <= (rd_next == RD_DATA);
            if (ar_hs) begin
                s_axi_rid   <= s_axi_arid;
                rd_len      <= s_axi_arlen;
                rd_beat     <= 8'd0;
                rd_size     <= ar_x.size;
                rd_burst    <= ar_x.burst;
                rd_err      <= ar_x.err;
                s_axi_rlast <= (s_axi_arlen == 8'd0);
                rd_addr     <= step_addr(s_axi_araddr, ar_x.size, ar_x.burst, s_axi_arlen);
            end else if (r_hs && !s_axi_rlast) begin
                rd_beat     <= rd_beat + 8'd1;
                s_axi_rlast <= ((rd_beat + 8'd1) == rd_len);
                rd_addr     <= step_addr(rd_addr, rd_size, rd_burst, rd_len);
            end
            if (ar_hs || (r_hs && !s_axi_rlast)) begin
                s_axi_rdata <= src_oob ? '0 : mem[widx(src_addr)];
                s_axi_rresp <= src_err ? 2'b10 : 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_axi_sram_responder.sv
// Bench for axi_sram_responder: table of AXI transactions checked through B/R scoreboards against a word model.
module tb_axi_sram_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] s_axi_awid = '0, s_axi_arid = '0, s_axi_bid, s_axi_rid;
    logic [11:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [7:0]  s_axi_awlen = '0, s_axi_arlen = '0;
    logic [2:0]  s_axi_awsize = '0, s_axi_arsize = '0;
    logic [1:0]  s_axi_awburst = '0, s_axi_arburst = '0, s_axi_bresp, s_axi_rresp;
    logic        s_axi_awvalid = 1'b0, s_axi_arvalid = 1'b0, s_axi_awready, s_axi_arready;
    logic [31:0] s_axi_wdata = '0, s_axi_rdata;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_wready;
    logic        s_axi_bvalid, s_axi_bready = 1'b0;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0;

    axi_sram_responder dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        logic [13:0] id;
        logic [11:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  strb;
        logic [31:0] base;
        int          bad_last;
        int          stall_beat;
        logic [1:0]  exp_resp;
        bit          chk0;
        logic [31:0] exp0;
    } vec_t;

    typedef struct packed {
        logic [13:0] id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct packed {
        logic [13:0] id;
        logic [1:0]  resp;
    } bexp_t;

    rbeat_t      rq[$];
    bexp_t       bq[$];
    logic [31:0] model [256];
    int          n_checks = 0;
    int          n_fail = 0;
    vec_t        tbl [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] beat_addr(input vec_t v, input int k);
        int sz, stp, blk;
        logic [1:0] b;
        sz  = (v.size > 3'd2) ? 2 : int'(v.size);
        stp = 1 << sz;
        b   = v.burst;
        if (b == 2'b11 || (b == 2'b10 && !(v.len == 1 || v.len == 3 || v.len == 7 || v.len == 15))) b = 2'b01;
        case (b)
            2'b00: return v.addr;
            2'b10: begin
                blk = (int'(v.len) + 1) * stp;
                return 12'((int'(v.addr) & ~(blk - 1)) | ((int'(v.addr) + k * stp) & (blk - 1)));
            end
            default: return 12'(int'(v.addr) + k * stp);
        endcase
    endfunction

    task automatic do_write(input vec_t v);
        bexp_t       e;
        int          n, idx;
        logic [31:0] d;
        e.id   = v.id;
        e.resp = v.exp_resp;
        bq.push_back(e);
        for (int k = 0; k <= int'(v.len); k++) begin
            idx = int'(beat_addr(v, k)) >> 2;
            d   = v.base + 32'(k);
            if (idx < 256)
                for (int b = 0; b < 4; b++)
                    if (v.strb[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        end
        s_axi_awid = v.id; s_axi_awaddr = v.addr; s_axi_awlen = v.len;
        s_axi_awsize = v.size; s_axi_awburst = v.burst; s_axi_awvalid = 1'b1;
        s_axi_wdata = v.base; s_axi_wstrb = v.strb; s_axi_wvalid = 1'b1;
        s_axi_wlast = (v.len == 0) || (v.bad_last == 0);
        n = 0;
        while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
        chk("awready", s_axi_awready, 1);
        chk("wready_before_aw", s_axi_wready, 0);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        for (int k = 0; k <= int'(v.len); k++) begin
            s_axi_wdata = v.base + 32'(k);
            s_axi_wlast = (k == int'(v.len)) || (k == v.bad_last);
            n = 0;
            while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
            chk("wready", s_axi_wready, 1);
            @(negedge clk);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        chk("b_latency", s_axi_bvalid, 1);
        e = bq.pop_front();
        chk("bid", s_axi_bid, e.id);
        chk("bresp", s_axi_bresp, e.resp);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        chk("b_done_awready", {s_axi_bvalid, s_axi_awready}, 2'b01);
    endtask

    task automatic do_read(input vec_t v);
        rbeat_t e;
        int     n, idx;
        for (int k = 0; k <= int'(v.len); k++) begin
            idx    = int'(beat_addr(v, k)) >> 2;
            e.id   = v.id;
            e.data = (idx < 256) ? model[idx] : 32'h0;
            e.resp = v.exp_resp;
            e.last = (k == int'(v.len));
            rq.push_back(e);
        end
        s_axi_arid = v.id; s_axi_araddr = v.addr; s_axi_arlen = v.len;
        s_axi_arsize = v.size; s_axi_arburst = v.burst; s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
        chk("arready", s_axi_arready, 1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        chk("r_latency", s_axi_rvalid, 1);
        for (int k = 0; k <= int'(v.len); k++) begin
            n = 0;
            while (!s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
            chk("rvalid", s_axi_rvalid, 1);
            e = rq.pop_front();
            if (k == v.stall_beat)
                repeat (2) begin
                    s_axi_rready = 1'b0;
                    chk("r_stall_hold", {s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast},
                        {1'b1, e.id, e.data, e.resp, e.last});
                    @(negedge clk);
                end
            if (k == 0 && v.chk0) chk("rdata_const", s_axi_rdata, v.exp0);
            chk("rid", s_axi_rid, e.id);
            chk("rdata", s_axi_rdata, e.data);
            chk("rresp", s_axi_rresp, e.resp);
            chk("rlast", s_axi_rlast, e.last);
            s_axi_rready = 1'b1;
            @(negedge clk);
            s_axi_rready = 1'b0;
            if (k < int'(v.len)) chk("r_next_beat", s_axi_rvalid, 1);
            else chk("r_done_arready", {s_axi_rvalid, s_axi_arready}, 2'b01);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          rd  id     addr     len  sz    bu     strb   base          bad stall resp   chk0 exp0
        tbl[0]  = '{0, 14'd5,  12'h010, 8'd0, 3'd2, 2'b01, 4'hF, 32'hDEADBEEF, -1, -1, 2'b00, 0, 32'h0};
        tbl[1]  = '{1, 14'd7,  12'h010, 8'd0, 3'd2, 2'b01, 4'h0, 32'h0,        -1, -1, 2'b00, 1, 32'hDEADBEEF};
        tbl[2]  = '{0, 14'd1,  12'h020, 8'd3, 3'd2, 2'b01, 4'hF, 32'h1,        -1, -1, 2'b00, 0, 32'h0};
        tbl[3]  = '{1, 14'd2,  12'h020, 8'd3, 3'd2, 2'b01, 4'h0, 32'h0,        -1,  1, 2'b00, 1, 32'h1};
        tbl[4]  = '{0, 14'd3,  12'h030, 8'd3, 3'd2, 2'b01, 4'hF, 32'hA0,       -1, -1, 2'b00, 0, 32'h0};
        tbl[5]  = '{1, 14'd4,  12'h038, 8'd3, 3'd2, 2'b10, 4'h0, 32'h0,        -1, -1, 2'b00, 1, 32'hA2};
        tbl[6]  = '{0, 14'd6,  12'h000, 8'd0, 3'd2, 2'b01, 4'hF, 32'h12345678, -1, -1, 2'b00, 0, 32'h0};
        tbl[7]  = '{0, 14'd8,  12'h400, 8'd0, 3'd2, 2'b01, 4'hF, 32'hCAFEF00D, -1, -1, 2'b10, 0, 32'h0};
        tbl[8]  = '{1, 14'd9,  12'h000, 8'd0, 3'd2, 2'b01, 4'h0, 32'h0,        -1, -1, 2'b00, 1, 32'h12345678};
        tbl[9]  = '{1, 14'hA,  12'h400, 8'd0, 3'd2, 2'b01, 4'h0, 32'h0,        -1, -1, 2'b10, 1, 32'h0};
        tbl[10] = '{0, 14'hB,  12'h040, 8'd3, 3'd2, 2'b01, 4'hF, 32'h50,        1, -1, 2'b10, 0, 32'h0};
        tbl[11] = '{0, 14'hC,  12'h050, 8'd0, 3'd2, 2'b01, 4'hF, 32'hFFFFFFFF, -1, -1, 2'b00, 0, 32'h0};
        tbl[12] = '{0, 14'hD,  12'h050, 8'd0, 3'd2, 2'b01, 4'h5, 32'h00000000, -1, -1, 2'b00, 0, 32'h0};
        tbl[13] = '{1, 14'hE,  12'h050, 8'd0, 3'd2, 2'b01, 4'h0, 32'h0,        -1, -1, 2'b00, 1, 32'hFF00FF00};
        tbl[14] = '{1, 14'hF,  12'h020, 8'd1, 3'd2, 2'b11, 4'h0, 32'h0,        -1, -1, 2'b10, 1, 32'h1};
        tbl[15] = '{1, 14'h10, 12'h024, 8'd2, 3'd2, 2'b00, 4'h0, 32'h0,        -1, -1, 2'b00, 1, 32'h2};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
                              s_axi_rlast, s_axi_bresp, s_axi_rresp}, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {s_axi_awready, s_axi_arready}, 2'b11);

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].is_rd) do_read(tbl[i]);
            else do_write(tbl[i]);
        end

        // Reset while beat 2 of a four-beat read is on the bus.
        s_axi_arid = 14'h21; s_axi_araddr = 12'h020; s_axi_arlen = 8'd3;
        s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_seq_beat2", {s_axi_rvalid, s_axi_rdata}, {1'b1, 32'h3});
        s_axi_rready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_read", {s_axi_rvalid, s_axi_arready, s_axi_rlast}, 3'b000);
        rst = 1'b1;
        @(negedge clk);
        chk("arready_after_rst", s_axi_arready, 1);
        do_read(tbl[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
